// File: rtl/ma_wb_stage_pkg.sv
// Shared pipeline definitions for the MEM->WB boundary: destination-select
// encodings, the link register number and a small occupancy helper.
package ma_wb_stage_pkg;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_LINK = 2'b10;
  localparam logic [1:0] DST_NONE = 2'b11;

  localparam int LINK_REG = 31;

  function automatic logic [1:0] occ_count(input logic main_vld, input logic skid_vld);
    return {1'b0, main_vld} + {1'b0, skid_vld};
  endfunction

endpackage

// File: rtl/ma_wb_stage_if.sv
// MEM->WB stage bus. Both sides use valid/ready: a transfer happens on a cycle
// where valid and ready are both 1; valid never waits on ready.
interface ma_wb_stage_if #(
  parameter int NBITS     = 32,
  parameter int NREG_BITS = 5
);
  logic                 i_valid;
  logic                 o_ready;
  logic [1:0]           i_flg_ALU_dst;
  logic                 i_flg_mem_op;
  logic [NBITS-1:0]     i_ALU_rslt;
  logic [NBITS-1:0]     i_data;
  logic [NREG_BITS-1:0] i_rd;
  logic [NREG_BITS-1:0] i_rt;
  logic                 i_flush;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_wb_en;
  logic [NREG_BITS-1:0] o_wb_addr;
  logic [NBITS-1:0]     o_wb_data;
  logic [1:0]           o_occupancy;

  modport slave (
    input  i_valid, i_flg_ALU_dst, i_flg_mem_op, i_ALU_rslt, i_data, i_rd, i_rt,
           i_flush, i_ready,
    output o_ready, o_valid, o_wb_en, o_wb_addr, o_wb_data, o_occupancy
  );

  modport master (
    output i_valid, i_flg_ALU_dst, i_flg_mem_op, i_ALU_rslt, i_data, i_rd, i_rt,
           i_flush, i_ready,
    input  o_ready, o_valid, o_wb_en, o_wb_addr, o_wb_data, o_occupancy
  );
endinterface

// File: rtl/ma_wb_stage_wb_resolve.sv
// Turns the head entry's stored fields into the register-file write:
// destination register, write data and the write strobe.
module wb_resolve
  import ma_wb_stage_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int NREG_BITS = 5
) (
  input  logic                 valid_i,
  input  logic                 ready_i,
  input  logic [1:0]           alu_dst_i,
  input  logic                 mem_op_i,
  input  logic [NBITS-1:0]     alu_rslt_i,
  input  logic [NBITS-1:0]     data_i,
  input  logic [NREG_BITS-1:0] rd_i,
  input  logic [NREG_BITS-1:0] rt_i,
  output logic                 wb_en_o,
  output logic [NREG_BITS-1:0] wb_addr_o,
  output logic [NBITS-1:0]     wb_data_o
);

  always_comb begin
    wb_addr_o = rt_i;
    case (alu_dst_i)
      DST_RD:   wb_addr_o = rd_i;
      DST_LINK: wb_addr_o = NREG_BITS'(LINK_REG);
      default:  wb_addr_o = rt_i;
    endcase
  end

  assign wb_data_o = mem_op_i ? data_i : alu_rslt_i;

  // Register 0 is hardwired, so a write to it is suppressed here.
  assign wb_en_o = valid_i & ready_i & (alu_dst_i != DST_NONE) & (wb_addr_o != '0);

endmodule

// File: rtl/ma_wb_stage.sv
// MEM->WB pipeline register built as a 2-entry skid buffer (main + skid) with
// a registered o_ready, feeding the write-back resolve logic from the main entry.
module ma_wb_stage
  import ma_wb_stage_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int NREG_BITS = 5
) (
  input logic          i_clk,
  input logic          i_rst,
  ma_wb_stage_if.slave bus
);

  typedef struct packed {
    logic [1:0]           alu_dst;
    logic                 mem_op;
    logic [NBITS-1:0]     alu_rslt;
    logic [NBITS-1:0]     data;
    logic [NREG_BITS-1:0] rd;
    logic [NREG_BITS-1:0] rt;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, in_entry;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, ready_q, ready_d;
  logic   accept, consume;

  assign in_entry = '{alu_dst: bus.i_flg_ALU_dst, mem_op: bus.i_flg_mem_op,
                      alu_rslt: bus.i_ALU_rslt, data: bus.i_data,
                      rd: bus.i_rd, rt: bus.i_rt};

  assign accept  = bus.i_valid & ready_q;
  assign consume = main_vld_q & bus.i_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (bus.i_flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (skid_vld_q) begin
      // ready_q is 0 here, so only a consume can happen.
      if (consume) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (main_vld_q) begin
      case ({accept, consume})
        2'b11: main_d = in_entry;
        2'b10: begin
          skid_d     = in_entry;
          skid_vld_d = 1'b1;
        end
        2'b01: main_vld_d = 1'b0;
        default: ;
      endcase
    end else if (accept) begin
      main_d     = in_entry;
      main_vld_d = 1'b1;
    end
    ready_d = ~skid_vld_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_valid     = main_vld_q;
  assign bus.o_occupancy = occ_count(main_vld_q, skid_vld_q);

  wb_resolve #(.NBITS(NBITS), .NREG_BITS(NREG_BITS)) u_wb_resolve (
    .valid_i    (main_vld_q),
    .ready_i    (bus.i_ready),
    .alu_dst_i  (main_q.alu_dst),
    .mem_op_i   (main_q.mem_op),
    .alu_rslt_i (main_q.alu_rslt),
    .data_i     (main_q.data),
    .rd_i       (main_q.rd),
    .rt_i       (main_q.rt),
    .wb_en_o    (bus.o_wb_en),
    .wb_addr_o  (bus.o_wb_addr),
    .wb_data_o  (bus.o_wb_data)
  );

endmodule

// File: doc/ma_wb_stage.md
MA_WB_STAGE -- requirements
Module: ma_wb_stage

Interface
REQ-001 Parameter NBITS, default 32: data-path width.
REQ-002 Parameter NREG_BITS, default 5: register-address width.
REQ-003 i_clk  in  1  clock.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_valid  in  1  upstream (MEM) entry valid.
REQ-006 o_ready  out  1  stage can accept an entry this cycle.
REQ-007 i_flg_ALU_dst  in  2  destination select: 00 rt, 01 rd, 10 register 31 (link), 11 no write.
REQ-008 i_flg_mem_op  in  1  1 = load, so write back i_data; 0 = write back i_ALU_rslt.
REQ-009 i_ALU_rslt, i_data  in  NBITS  ALU result, memory read data.
REQ-010 i_rd, i_rt  in  NREG_BITS  register numbers.
REQ-011 i_flush  in  1  discard all held entries.
REQ-012 o_valid  out  1  head entry valid toward WB.
REQ-013 i_ready  in  1  WB consumes head entry.
REQ-014 o_wb_en  out  1  register-file write strobe.
REQ-015 o_wb_addr  out  NREG_BITS  resolved destination register.
REQ-016 o_wb_data  out  NBITS  resolved write-back data.
REQ-017 o_occupancy  out  2  entries held, 0..2.

Function
REQ-018 Stage SHALL be a 2-entry skid buffer, main entry plus skid entry, each storing {ALU_dst, mem_op, ALU_rslt, data, rd, rt}.
REQ-019 o_ready SHALL be registered and equal 1 exactly when the skid entry is empty.
REQ-020 Accept SHALL occur on i_valid & o_ready; consume SHALL occur on o_valid & i_ready.
REQ-021 Latency SHALL be 1 cycle: an entry accepted with both entries empty SHALL appear at the head on the next cycle.
REQ-022 Accept without consume while main is full SHALL load the skid entry, making o_ready 0 next cycle.
REQ-023 Consume with skid full SHALL move skid to main; simultaneous accept is impossible because o_ready is 0.
REQ-024 Simultaneous accept and consume with only main full SHALL replace main with the new entry, so occupancy stays 1.
REQ-025 Entries SHALL leave in arrival order; no entry SHALL be lost or duplicated.
REQ-026 o_valid SHALL equal main-entry valid.
REQ-027 o_wb_addr SHALL be rt, rd, all-ones (31), or rt for ALU_dst 00, 01, 10, or 11 respectively, taken from the head entry.
REQ-028 o_wb_data SHALL be the head entry's data if mem_op is 1, else its ALU_rslt; the selection is combinational from stored fields.
REQ-029 o_wb_en SHALL equal o_valid & i_ready & (ALU_dst != 11) & (o_wb_addr != 0).
REQ-030 i_flush SHALL invalidate both entries at the next edge and take priority over a simultaneous accept, which is dropped; the next cycle SHALL show o_valid 0, o_ready 1, occupancy 0.
REQ-031 o_wb_en SHALL stay asserted during a flush cycle if REQ-029 holds, because the head entry is committed.

Reset
REQ-032 On i_rst, both entries SHALL be invalid and all stored fields 0.
REQ-033 After reset: o_valid 0, o_ready 1, o_occupancy 0, o_wb_en 0, o_wb_addr 0, o_wb_data 0.
REQ-034 Reset SHALL override flush, accept and consume, including mid-stall with the skid entry full.

Structure
REQ-035 ALU_dst encodings (DST_RT, DST_RD, DST_LINK, DST_NONE) and the link register number 31 SHALL reside in the shared pipeline package.
REQ-036 The write-back resolve logic (REQ-027/028) SHALL be one sub-module, wb_resolve; the skid buffer is in the top module.

Verification
REQ-037 Stream: load, ALU_dst 01, rd 7, data 0xDEADBEEF, i_ready 1 -> next cycle o_wb_en 1, o_wb_addr 7, o_wb_data 0xDEADBEEF.
REQ-038 Stall: accept A (ALU 0x11, rt 3), then B (ALU 0x22), with i_ready 0 -> occupancy 2, o_ready 0; after raising i_ready -> writes to r3=0x11, then B, in order.
REQ-039 Link/no-write: ALU_dst 10, ALU 0x400 -> wb_addr 31, data 0x400; ALU_dst 11 -> o_wb_en 0; rd 0 with ALU_dst 01 -> o_wb_en 0.
REQ-040 Flush: occupancy 2 with i_valid 1 and i_flush 1 -> next cycle occupancy 0, o_valid 0, o_ready 1, incoming entry dropped.
REQ-041 Reset while skid full -> all outputs at REQ-033 values next cycle; first post-reset entry emerges after 1 cycle.
REQ-042 Random i_valid/i_ready at NBITS=64 with a scoreboard -> ordering and no loss/duplication hold, and o_ready never 1 while occupancy is 2.
